// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: one transaction in flight, round-robin or fixed
// priority, access validation, and sign/zero handling left to the memory via m_memop.
module dmem_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [2:0]  memop0,
  input  logic [2:0]  memop1,
  input  logic [16:0] addr0,
  input  logic [16:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic [2:0]  m_memop,
  output logic [31:0] m_data,
  output logic [16:0] m_rdaddr,
  output logic [16:0] m_wraddr,
  output logic        m_wren,
  input  logic [31:0] m_dataout
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RWAIT  = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  typedef struct packed {
    logic        we;
    logic [2:0]  memop;
    logic [16:0] addr;
    logic [31:0] wdata;
  } req_t;

  logic [1:0] state;
  logic       gnt, last_gnt, err_q, we_q;
  logic       sel, bad;
  req_t       s;

  // Both requesting: RR picks the port not served last, fixed picks port 0.
  assign sel = req1 && (!req0 || (RR_EN && !last_gnt));

  always_comb begin
    s = sel ? {we1, memop1, addr1, wdata1} : {we0, memop0, addr0, wdata0};
    bad = 1'b0;
    case (s.memop)
      3'b011, 3'b110, 3'b111: bad = 1'b1;
      3'b100:                 bad = s.we;
      3'b101:                 bad = s.we | s.addr[0];
      3'b001:                 bad = s.addr[0];
      3'b010:                 bad = |s.addr[1:0];
      default:                bad = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= 1'b0;
      last_gnt <= 1'b1;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
      m_memop  <= 3'b000;
      m_data   <= '0;
      m_rdaddr <= '0;
      m_wraddr <= '0;
      m_wren   <= 1'b0;
      rdata0   <= '0;
      rdata1   <= '0;
    end else begin
      case (state)
        IDLE: if (req0 || req1) begin
          gnt      <= sel;
          last_gnt <= sel;
          err_q    <= bad;
          we_q     <= s.we;
          // Rejected requests never touch the memory-side registers.
          if (bad) state <= DONE;
          else begin
            state    <= ACCESS;
            m_memop  <= s.memop;
            m_rdaddr <= s.addr;
            m_wraddr <= s.addr;
            m_data   <= s.wdata;
            m_wren   <= s.we;
          end
        end
        ACCESS: begin
          m_wren <= 1'b0;
          state  <= we_q ? DONE : RWAIT;
        end
        RWAIT: begin
          if (gnt) rdata1 <= m_dataout;
          else     rdata0 <= m_dataout;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ack0 = (state == DONE) && !gnt;
  assign ack1 = (state == DONE) && gnt;
  assign err0 = ack0 && err_q;
  assign err1 = ack1 && err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed transactions push expected acks,
// a negedge monitor pops and compares; a behavioral sync-read memory backs instance a.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [2:0]  memop0 = 0, memop1 = 0;
  logic [16:0] addr0 = 0, addr1 = 0;
  logic [31:0] wdata0 = 0, wdata1 = 0;

  logic        a_ack0, a_ack1, a_err0, a_err1, a_m_wren;
  logic [31:0] a_rdata0, a_rdata1, a_m_data, m_dataout;
  logic [2:0]  a_m_memop;
  logic [16:0] a_m_rdaddr, a_m_wraddr;

  logic        b_ack0, b_ack1, b_err0, b_err1, b_m_wren;
  logic [31:0] b_rdata0, b_rdata1, b_m_data;
  logic [2:0]  b_m_memop;
  logic [16:0] b_m_rdaddr, b_m_wraddr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_arbiter #(.RR_EN(1'b1)) dut_a (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .memop0(memop0), .memop1(memop1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .ack0(a_ack0), .ack1(a_ack1),
    .err0(a_err0), .err1(a_err1), .rdata0(a_rdata0), .rdata1(a_rdata1),
    .m_memop(a_m_memop), .m_data(a_m_data), .m_rdaddr(a_m_rdaddr),
    .m_wraddr(a_m_wraddr), .m_wren(a_m_wren), .m_dataout(m_dataout));

  dmem_arbiter #(.RR_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .memop0(memop0), .memop1(memop1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .ack0(b_ack0), .ack1(b_ack1),
    .err0(b_err0), .err1(b_err1), .rdata0(b_rdata0), .rdata1(b_rdata1),
    .m_memop(b_m_memop), .m_data(b_m_data), .m_rdaddr(b_m_rdaddr),
    .m_wraddr(b_m_wraddr), .m_wren(b_m_wren), .m_dataout(32'h0));

  // Little-endian byte memory, synchronous read, extension per m_memop
  logic [7:0] mem [0:131071];
  initial for (int i = 0; i < 131072; i++) mem[i] = 8'h00;

  function automatic logic [31:0] rd_mem(input logic [16:0] a, input logic [2:0] op);
    logic [16:0] a1, w;
    a1 = a + 17'd1;
    w  = {a[16:2], 2'b00};
    case (op)
      3'b000:  return {{24{mem[a][7]}}, mem[a]};
      3'b100:  return {24'h0, mem[a]};
      3'b001:  return {{16{mem[a1][7]}}, mem[a1], mem[a]};
      3'b101:  return {16'h0, mem[a1], mem[a]};
      3'b010:  return {mem[w | 17'd3], mem[w | 17'd2], mem[w | 17'd1], mem[w]};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    m_dataout <= rd_mem(a_m_rdaddr, a_m_memop);
    if (a_m_wren) begin
      case (a_m_memop[1:0])
        2'b00: mem[a_m_wraddr] <= a_m_data[7:0];
        2'b01: begin
          mem[a_m_wraddr]         <= a_m_data[7:0];
          mem[a_m_wraddr + 17'd1] <= a_m_data[15:8];
        end
        2'b10: begin
          mem[{a_m_wraddr[16:2], 2'b00}] <= a_m_data[7:0];
          mem[{a_m_wraddr[16:2], 2'b01}] <= a_m_data[15:8];
          mem[{a_m_wraddr[16:2], 2'b10}] <= a_m_data[23:16];
          mem[{a_m_wraddr[16:2], 2'b11}] <= a_m_data[31:24];
        end
        default: ;
      endcase
    end
  end

  typedef struct {
    bit          port;
    bit          err;
    bit          chk_rd;
    logic [31:0] rd;
    int          cyc;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every ack on instance a must match the head of the scoreboard
  always @(negedge clk) begin
    if (a_ack0 || a_ack1) begin
      exp_t e;
      chk("ack_onehot", {31'h0, a_ack0 & a_ack1}, 32'h0);
      if (q.size() == 0) chk("unexpected_ack", {30'h0, a_ack1, a_ack0}, 32'h0);
      else begin
        e = q.pop_front();
        chk("ack_port", {31'h0, a_ack1}, {31'h0, e.port});
        chk("ack_cycle", cyc, e.cyc);
        chk("ack_err", {31'h0, e.port ? a_err1 : a_err0}, {31'h0, e.err});
        if (e.chk_rd) chk("rdata", e.port ? a_rdata1 : a_rdata0, e.rd);
      end
    end
  end

  // Called at a negedge with the DUT idle; returns at a negedge back in IDLE.
  task automatic issue(input bit p, input bit we, input logic [2:0] op,
                       input logic [16:0] a, input logic [31:0] wd,
                       input bit ex_err, input bit chk_rd, input logic [31:0] ex_rd,
                       input bit chg);
    exp_t e;
    int wc;
    logic [16:0] wa, ra0, wa0;
    bit got;
    ra0 = a_m_rdaddr;
    wa0 = a_m_wraddr;
    if (p) begin req1 = 1; we1 = we; memop1 = op; addr1 = a; wdata1 = wd; end
    else   begin req0 = 1; we0 = we; memop0 = op; addr0 = a; wdata0 = wd; end
    e.port = p; e.err = ex_err; e.chk_rd = chk_rd; e.rd = ex_rd;
    e.cyc = cyc + (ex_err ? 1 : (we ? 2 : 3));
    q.push_back(e);
    wc = 0; wa = '0; got = 0;
    for (int k = 1; k <= 10 && !got; k++) begin
      @(negedge clk);
      if (chg && k == 2) begin
        if (p) addr1 = a ^ 17'h4; else addr0 = a ^ 17'h4;
      end
      if (a_m_wren) begin wc++; wa = a_m_wraddr; end
      if (p ? a_ack1 : a_ack0) got = 1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL ack_timeout port=%0d no ack within 10 cycles", p);
      q.delete();
    end
    req0 = 0; req1 = 0;
    chk("wren_cycles", wc, (we && !ex_err) ? 32'd1 : 32'd0);
    if (wc != 0) chk("wr_addr", {15'h0, wa}, {15'h0, a});
    if (ex_err) begin
      chk("err_rdaddr_held", {15'h0, a_m_rdaddr}, {15'h0, ra0});
      chk("err_wraddr_held", {15'h0, a_m_wraddr}, {15'h0, wa0});
    end
    @(negedge clk);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ack"}, {28'h0, a_ack0, a_ack1, a_err0, a_err1}, 32'h0);
    chk({tag, "_wren"}, {31'h0, a_m_wren}, 32'h0);
    chk({tag, "_memop"}, {29'h0, a_m_memop}, 32'h0);
    chk({tag, "_mdata"}, a_m_data, 32'h0);
    chk({tag, "_addrs"}, {15'h0, a_m_rdaddr} | {15'h0, a_m_wraddr}, 32'h0);
    chk({tag, "_rdata0"}, a_rdata0, 32'h0);
    chk({tag, "_rdata1"}, a_rdata1, 32'h0);
  endtask

  initial begin
    int n, cb0, cb1;
    exp_t e;
    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    rst = 0;
    @(negedge clk);
    chk("no_ack_after_reset", {30'h0, a_ack1, a_ack0}, 32'h0);

    // Word store/load on port 0
    issue(0, 1, 3'b010, 17'h00010, 32'h12345678, 0, 0, 0, 0);
    issue(0, 0, 3'b010, 17'h00010, 32'h0,        0, 1, 32'h12345678, 0);
    // Byte store then signed/unsigned loads on port 1
    issue(1, 1, 3'b000, 17'h00013, 32'h00000080, 0, 0, 0, 0);
    issue(1, 0, 3'b000, 17'h00013, 32'h0,        0, 1, 32'hFFFFFF80, 0);
    issue(1, 0, 3'b100, 17'h00013, 32'h0,        0, 1, 32'h00000080, 0);
    // Half store then signed/unsigned loads
    issue(0, 1, 3'b001, 17'h00016, 32'h0000BEEF, 0, 0, 0, 0);
    issue(0, 0, 3'b001, 17'h00016, 32'h0,        0, 1, 32'hFFFFBEEF, 0);
    issue(1, 0, 3'b101, 17'h00016, 32'h0,        0, 1, 32'h0000BEEF, 0);
    // Rejected requests
    issue(0, 0, 3'b010, 17'h00002, 32'h0,        1, 0, 0, 0);
    issue(1, 1, 3'b001, 17'h00001, 32'h0000FFFF, 1, 0, 0, 0);
    issue(0, 0, 3'b011, 17'h00000, 32'h0,        1, 0, 0, 0);
    issue(1, 1, 3'b100, 17'h00008, 32'h000000AA, 1, 0, 0, 0);
    // Address changed during RWAIT; byte 0x13 now holds 0x80
    issue(0, 0, 3'b010, 17'h00010, 32'h0,        0, 1, 32'h80345678, 1);

    // Reset in ACCESS of a store aborts it
    req0 = 1; we0 = 1; memop0 = 3'b010; addr0 = 17'h00030; wdata0 = 32'hDEADBEEF;
    @(negedge clk);
    chk("abort_access_wren", {31'h0, a_m_wren}, 32'h1);
    rst = 1;
    @(negedge clk);
    chk_reset_state("abort");
    rst = 0; req0 = 0;
    repeat (4) @(negedge clk);

    // Both requests held: RR alternates from port 0, fixed priority serves port 0
    n = cyc;
    req0 = 1; we0 = 1; memop0 = 3'b010; addr0 = 17'h00020; wdata0 = 32'hAAAA0000;
    req1 = 1; we1 = 1; memop1 = 3'b010; addr1 = 17'h00024; wdata1 = 32'hBBBB0000;
    for (int i = 0; i < 4; i++) begin
      e.port = i[0]; e.err = 0; e.chk_rd = 0; e.rd = 0; e.cyc = n + 2 + 3 * i;
      q.push_back(e);
    end
    cb0 = 0; cb1 = 0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (b_ack0) cb0++;
      if (b_ack1) cb1++;
    end
    req0 = 0; req1 = 0;
    chk("fixed_prio_ack0_count", cb0, 32'd4);
    chk("fixed_prio_ack1_count", cb1, 32'd0);
    repeat (3) @(negedge clk);

    chk("scoreboard_drained", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
